instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/cpu16_pkg.sv | 35 +++
 rtl/instr_fifo.sv | 59 +++++
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared constants for the 16-bit instruction encoder: opcodes, field
// positions, immediate limits and the write-FSM state type.
package cpu16_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLI  = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int RS_MSB    = 12;
    localparam int RS_LSB    = 10;
    localparam int RT_MSB    = 9;
    localparam int RT_LSB    = 7;
    localparam int RD_MSB    = 6;
    localparam int RD_LSB    = 4;
    localparam int FUNCT_MSB = 3;
    localparam int IMM_MSB   = 6;
    localparam int TGT_MSB   = 12;

    localparam int SLI_MAX  = 127;
    localparam int SIMM_MIN = -64;
    localparam int SIMM_MAX = 63;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead staging FIFO; rdata always presents the head entry.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointer wrap handles depths that are not a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && (int'(count) < DEPTH);
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes and range-checks instructions, stages them in a FIFO and writes
// them to instruction memory at consecutive addresses under imem_ack.
module instr_encoder
    import cpu16_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] START_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  opcode,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [2:0]  rd,
    input  logic [3:0]  funct,
    input  logic [15:0] imm,
    input  logic [15:0] target,
    input  logic        addr_load,
    input  logic [15:0] addr_init,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    input  logic        imem_ack,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [15:0] words_written,
    output logic        busy,
    output wr_state_t   fsm_state
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wr_state_t     state;
    wr_state_t     state_next;
    logic [15:0]   enc;
    logic          legal;
    logic          accept;
    logic          pop;
    logic          wr_done;
    logic          fifo_empty;
    logic [15:0]   head;
    logic [CW-1:0] fifo_count;

    always_comb begin
        enc                  = '0;
        legal                = 1'b1;
        enc[OP_MSB:OP_LSB]   = opcode;
        case (opcode)
            OP_ADD: begin
                enc[RS_MSB:RS_LSB]   = rs;
                enc[RT_MSB:RT_LSB]   = rt;
                enc[RD_MSB:RD_LSB]   = rd;
                enc[FUNCT_MSB:0]     = funct;
            end
            OP_J, OP_JAL: begin
                enc[TGT_MSB:0] = target[TGT_MSB:0];
                legal          = (target[15:TGT_MSB+1] == '0);
            end
            OP_SLI: begin
                enc[RS_MSB:RS_LSB] = rs;
                enc[RT_MSB:RT_LSB] = rt;
                enc[IMM_MSB:0]     = imm[IMM_MSB:0];
                legal              = (int'(imm) <= SLI_MAX);
            end
            default: begin
                enc[RS_MSB:RS_LSB] = rs;
                enc[RT_MSB:RT_LSB] = rt;
                enc[IMM_MSB:0]     = imm[IMM_MSB:0];
                legal = (int'($signed(imm)) >= SIMM_MIN) && (int'($signed(imm)) <= SIMM_MAX);
            end
        endcase
    end

    assign in_ready   = (int'(fifo_count) < FIFO_DEPTH);
    assign accept     = in_valid && in_ready;
    assign fifo_empty = (fifo_count == '0);

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && legal),
        .wdata (enc),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_WRITE;
            ST_WRITE: if (imem_ack && fifo_empty) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Acked write with more data pending pops immediately, so writes stream back-to-back.
    always_comb begin
        imem_we = (state == ST_WRITE);
        wr_done = (state == ST_WRITE) && imem_ack;
        pop     = !fifo_empty && ((state == ST_IDLE) || wr_done);
        busy    = (state == ST_WRITE) || !fifo_empty;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_addr     <= START_ADDR;
            imem_wdata    <= '0;
            words_written <= '0;
            err           <= 1'b0;
            err_count     <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            if (pop) begin
                imem_wdata <= head;
            end
            if (wr_done) begin
                imem_addr     <= imem_addr + 16'd1;
                words_written <= words_written + 16'd1;
            end else if (addr_load && state == ST_IDLE && fifo_empty) begin
                imem_addr     <= addr_init;
                words_written <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;
    import cpu16_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [15:0] START = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  opcode = '0;
    logic [2:0]  rs = '0;
    logic [2:0]  rt = '0;
    logic [2:0]  rd = '0;
    logic [3:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [15:0] target = '0;
    logic        addr_load = 1'b0;
    logic [15:0] addr_init = '0;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_ack = 1'b0;
    logic        err;
    logic [7:0]  err_count;
    logic [15:0] words_written;
    logic        busy;
    wr_state_t   dbg_state;

    logic [15:0] exp_q[$];
    logic [15:0] m_addr;
    logic [15:0] m_words;
    logic [7:0]  m_errs;
    logic        err_exp;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .FIFO_DEPTH (DEPTH),
        .START_ADDR (START)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .funct         (funct),
        .imm           (imm),
        .target        (target),
        .addr_load     (addr_load),
        .addr_init     (addr_init),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_ack      (imem_ack),
        .err           (err),
        .err_count     (err_count),
        .words_written (words_written),
        .busy          (busy),
        .fsm_state     (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference encoding built by weighting each field by its bit position.
    function automatic logic [15:0] ref_word(input logic [2:0] op, input logic [2:0] a,
                                             input logic [2:0] b, input logic [2:0] c,
                                             input logic [3:0] f, input logic [15:0] im,
                                             input logic [15:0] tg);
        int w;
        w = int'(op) * 8192;
        if (op == 3'd0)                   w += int'(a) * 1024 + int'(b) * 128 + int'(c) * 16 + int'(f);
        else if (op == 3'd2 || op == 3'd3) w += int'(tg) % 8192;
        else                              w += int'(a) * 1024 + int'(b) * 128 + int'(im) % 128;
        return 16'(w);
    endfunction

    function automatic bit ref_legal(input logic [2:0] op, input logic [15:0] im, input logic [15:0] tg);
        int s;
        s = $signed(im);
        case (op)
            3'd0:       return 1'b1;
            3'd1:       return int'(im) <= 127;
            3'd2, 3'd3: return int'(tg) < 8192;
            default:    return (s >= -64) && (s <= 63);
        endcase
    endfunction

    task automatic set_instr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                             input logic [2:0] c, input logic [3:0] f, input logic [15:0] im,
                             input logic [15:0] tg);
        opcode = op; rs = a; rt = b; rd = c; funct = f; imm = im; target = tg;
        in_valid = 1'b1;
    endtask

    task automatic rand_instr();
        logic [15:0] im;
        logic [15:0] tg;
        case ($urandom_range(0, 3))
            0:       im = 16'($urandom);
            1:       im = 16'($urandom_range(0, 130));
            default: im = 16'hFFFF - 16'($urandom_range(0, 70));
        endcase
        tg = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191));
        set_instr(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                  4'($urandom), im, tg);
    endtask

    // Called just after a falling edge with inputs set; predicts the next rising edge.
    task automatic cycle();
        int  pending;
        logic [15:0] e;
        bit  acc;
        bit  lg;
        #1;
        pending = exp_q.size();
        if (imem_we && imem_ack) begin
            if (pending == 0) begin
                check("spurious_write", imem_we, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wdata", imem_wdata, e);
                check("waddr", imem_addr, m_addr);
                m_addr++;
                m_words++;
            end
        end
        if (addr_load && pending == 0) begin
            m_addr  = addr_init;
            m_words = '0;
        end
        acc = in_valid && in_ready;
        lg  = ref_legal(opcode, imm, target);
        err_exp = acc && !lg;
        if (acc && lg) exp_q.push_back(ref_word(opcode, rs, rt, rd, funct, imm, target));
        if (acc && !lg && m_errs != 8'hFF) m_errs++;
        @(posedge clk);
        @(negedge clk);
        check("err", err, err_exp);
        check("err_count", err_count, m_errs);
        check("words_written", words_written, m_words);
        check("busy", busy, exp_q.size() != 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_addr = START; m_words = '0; m_errs = '0; err_exp = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, START);
        check("rst_wdata", imem_wdata, 16'h0000);
        check("rst_err", err, 1'b0);
        check("rst_err_count", err_count, 8'h00);
        check("rst_words", words_written, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; imem_ack = 1'b0; addr_load = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_state();
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        clear_model();
        // Test 1: single add, latency and address advance.
        do_reset();
        set_instr(OP_ADD, 3'd1, 3'd2, 3'd3, 4'd0, 16'h0, 16'h0);
        cycle();
        in_valid = 1'b0;
        check("t1_we_before", imem_we, 1'b0);
        cycle();
        check("t1_we", imem_we, 1'b1);
        check("t1_addr", imem_addr, 16'h0000);
        check("t1_data", imem_wdata, 16'h0530);
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
        check("t1_addr_after", imem_addr, 16'h0001);
        check("t1_words", words_written, 16'h0001);
        check("t1_we_after", imem_we, 1'b0);

        // Test 2: addi at both sides of the signed limit.
        set_instr(OP_ADDI, 3'd0, 3'd0, 3'd0, 4'd0, 16'hFFFF, 16'h0);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("t2_data", imem_wdata, 16'hE07F);
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
        set_instr(OP_ADDI, 3'd0, 3'd0, 3'd0, 4'd0, 16'd64, 16'h0);
        cycle();
        in_valid = 1'b0;
        check("t2_err_pulse", err, 1'b1);
        check("t2_err_count", err_count, 8'd1);
        check("t2_no_we", imem_we, 1'b0);
        cycle();
        check("t2_err_clear", err, 1'b0);
        check("t2_no_we2", imem_we, 1'b0);

        // Test 3: fill with ack low, then drain back-to-back.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_instr(OP_ADD, 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 16'h0, 16'h0);
            check("t3_ready", in_ready, 1'b1);
            cycle();
        end
        check("t3_full", in_ready, 1'b0);
        set_instr(OP_ADD, 3'd7, 3'd7, 3'd7, 4'd15, 16'h0, 16'h0);
        cycle();
        check("t3_still_full", in_ready, 1'b0);
        in_valid = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_we_run", imem_we, 1'b1);
            cycle();
        end
        imem_ack = 1'b0;
        check("t3_we_done", imem_we, 1'b0);
        check("t3_words", words_written, 16'd5);

        // Test 4: address wrap from FFFF.
        do_reset();
        addr_load = 1'b1; addr_init = 16'hFFFF;
        cycle();
        addr_load = 1'b0;
        check("t4_loaded", imem_addr, 16'hFFFF);
        set_instr(OP_J, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0, 16'h0010);
        cycle();
        cycle();
        in_valid = 1'b0;
        check("t4_addr0", imem_addr, 16'hFFFF);
        check("t4_data0", imem_wdata, 16'h4010);
        imem_ack = 1'b1;
        cycle();
        check("t4_we1", imem_we, 1'b1);
        check("t4_addr1", imem_addr, 16'h0000);
        check("t4_data1", imem_wdata, 16'h4010);
        cycle();
        imem_ack = 1'b0;
        check("t4_addr_end", imem_addr, 16'h0001);

        // Test 5: asynchronous reset while writing with three words queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_instr(OP_ADD, 3'd1, 3'($urandom), 3'd2, 4'($urandom), 16'h0, 16'h0);
            cycle();
        end
        in_valid = 1'b0;
        check("t5_we_before", imem_we, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_we_now", imem_we, 1'b0);
        check("t5_busy_now", busy, 1'b0);
        check("t5_addr_now", imem_addr, START);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_addr_after", imem_addr, START);

        // Test 6: err_count saturation.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            set_instr(OP_SLI, 3'd0, 3'd0, 3'd0, 4'd0, 16'd200 + 16'(i), 16'h0);
            cycle();
        end
        in_valid = 1'b0;
        check("t6_sat", err_count, 8'hFF);

        // Test 7: random traffic against the model, then drain.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 7) rand_instr();
            else in_valid = 1'b0;
            imem_ack  = ($urandom_range(0, 9) < 6);
            addr_load = ($urandom_range(0, 19) == 0);
            addr_init = ($urandom_range(0, 1) == 0) ? 16'hFFFE : 16'($urandom);
            cycle();
        end
        in_valid = 1'b0; addr_load = 1'b0; imem_ack = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        check("t7_drained", exp_q.size(), 0);
        check("t7_idle", imem_we, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
